regfile_loader: RTL
===================

// Module: regfile_loader
// PURPOSE
//  Write-side sequencer for the 32x64 register file: on a start pulse it drives
//  we3/wa3/wd3 to fill X0..X30 with an index pattern or with values streamed in.
//  X31 (XZR) is never written. Sits beside regfile in SingleCycleProcessor; used for
//  boot/test initialisation before the datapath owns the write port.
// PARAMETERS
//  N         64   data width of wd3 / s_data / rd1
//  LAST_REG  30   highest register written (X31 = XZR, excluded)
// PORTS
//  clk       in   1  single clock; all state updates on posedge clk
//  reset     in   1  synchronous, active-high reset
//  start     in   1  one-cycle request; sampled only in IDLE
//  mode      in   1  0 = index pattern (wd3 = register index), 1 = stream from s_data
//  s_valid   in   1  stream data valid (mode 1)
//  s_data    in   N  stream data (mode 1)
//  s_ready   out  1  loader accepts s_data this cycle
//  we3       out  1  regfile write enable
//  wa3       out  5  regfile write address
//  wd3       out  N  regfile write data
//  ra1       out  5  regfile read address (readback, see CONFIGURATION)
//  rd1       in   N  regfile read data (combinational from ra1)
//  busy      out  1  high in WRITE/VERIFY
//  done      out  1  one-cycle pulse on completion
//  err       out  1  sticky readback mismatch; cleared by reset or accepted start
//  err_addr  out  5  address of first mismatch
// BEHAVIOUR
//  - Reset: state IDLE, addr=0; we3, s_ready, busy, done, err = 0; wa3, ra1,
//    err_addr = 0; wd3 = 0.
//  - FSM: IDLE -> WRITE on start (mode latched; err cleared); WRITE -> VERIFY after
//    write to LAST_REG (macro on, mode 0) else -> DONE; VERIFY -> DONE after ra1=31;
//    DONE -> IDLE unconditionally (done=1 for exactly that cycle).
//  - WRITE mode 0: one write per cycle, we3=1, wa3=addr, wd3=zero-extended addr;
//    31 cycles, addr 0..30.
//  - WRITE mode 1: s_ready=1 throughout WRITE; write occurs only on cycle with
//    s_valid&&s_ready: we3=1, wa3=addr, wd3=s_data (combinational pass-through).
//    we3=0 on cycles without handshake; addr increments per handshake only.
//  - Mode 1 never enters VERIFY (no expected-value storage).
//  - start while busy or in DONE: ignored. mode changes mid-operation: ignored.
//  - Reset mid-operation: next cycle IDLE, we3=0, no done pulse, partial writes stand.
//  - addr is 5-bit; never exceeds 31; no wrap.
// CONFIGURATION
//  REGFILE_LOADER_VERIFY_EN defined: after mode-0 WRITE, VERIFY drives ra1=0..31, one
//    per cycle (32 cycles); expected rd1 = index for 0..30, 0 for 31. First mismatch
//    sets err=1, err_addr=ra1; later mismatches do not overwrite. Sequence always
//    completes. Mode-0 total latency start->done: 31+32+1 cycles.
//  Undefined: no VERIFY state; ra1 tied 0, rd1 unused, err/err_addr constant 0.
//    Mode-0 latency start->done: 31+1 cycles.
// STRUCTURE
//  - regfile_pkg: NREGS=32, XZR_ADDR=5'd31, LAST_REG default, loader_state_t enum
//    {IDLE, WRITE, VERIFY, DONE}.
//  - Single module; no sub-module (one 5-bit address counter, one FSM, one comparator).
// TESTING (bench instantiates regfile + regfile_loader)
//  1. reset, start mode 0 -> we3=1 for 31 consecutive cycles, wa3 0..30, wd3=wa3;
//     regfile reads X5=5, X31=0; done pulse once; busy low after.
//  2. mode 1, s_valid toggling 1,0,1,1,0 pattern, s_data=0xA000+i -> exactly 31 writes,
//     X i = 0xA000+i, done one cycle after 31st handshake, we3=0 on gap cycles.
//  3. macro on, clean regfile -> err=0 after done; force rd1=0xDEAD when ra1=7 ->
//     err=1, err_addr=7, done still asserts at cycle 64.
//  4. macro on, force rd1=1 when ra1=31 -> err=1, err_addr=31.
//  5. start asserted at cycles 3 and 20 of a run -> ignored, single done pulse.
//  6. reset at WRITE cycle 10 -> next cycle we3=0, busy=0, no done; X0..X9 written.

Source files
------------

// File: rtl/regfile_loader_pkg.sv
// regfile_loader_pkg
//   Shared constants and types for the register-file write-side loader.
//   NREGS / XZR_ADDR describe the 32-entry register file whose top entry
//   (X31, the zero register) is read-only zero. LAST_REG_DEFAULT is the
//   highest register the loader fills. loader_state_t is the loader FSM
//   state type.
package regfile_loader_pkg;

   localparam int         NREGS            = 32;
   localparam logic [4:0] XZR_ADDR         = 5'd31;
   localparam int         LAST_REG_DEFAULT = 30;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } loader_state_t;

   // Value a healthy register file returns at address a after an index
   // fill: the index itself, except the zero register which always reads 0.
   function automatic logic [4:0] expected_index(input logic [4:0] a);
      return (a == XZR_ADDR) ? 5'd0 : a;
   endfunction

endpackage

// File: rtl/regfile_loader_if.sv
// regfile_loader_if
//   Bundles the loader's data-plane signals: the input stream
//   (s_valid / s_data / s_ready) and the register-file ports
//   (write: we3 / wa3 / wd3, readback: ra1 / rd1).
//   modport master : the loader side (drives s_ready and the regfile port).
//   modport slave  : the environment side (stream source + register file).
interface regfile_loader_if #(
   parameter int N = 64
);
   logic         s_valid;
   logic [N-1:0] s_data;
   logic         s_ready;
   logic         we3;
   logic [4:0]   wa3;
   logic [N-1:0] wd3;
   logic [4:0]   ra1;
   logic [N-1:0] rd1;

   modport master (
      input  s_valid, s_data, rd1,
      output s_ready, we3, wa3, wd3, ra1
   );

   modport slave (
      output s_valid, s_data, rd1,
      input  s_ready, we3, wa3, wd3, ra1
   );
endinterface

// File: rtl/regfile_loader.sv
// regfile_loader
//   Write-side sequencer for the 32x64 register file. A start pulse in IDLE
//   fills X0..X(LAST_REG) either with the register index (mode 0) or with
//   words taken from the input stream (mode 1). X31 is never written.
//
//   Optional feature: define REGFILE_LOADER_VERIFY_EN to add a readback pass
//   after a mode-0 fill. It walks ra1 over 0..31, compares rd1 with the
//   expected index (0 for X31) and records the first mismatching address.
//   Without the macro there is no readback: ra1 is 0 and err/err_addr are 0.
//
// Ports
//   clk       clock, all state changes on its rising edge
//   reset     synchronous active-high reset
//   start     one-cycle request, only honoured in IDLE
//   mode      0 = index pattern, 1 = stream; latched on an accepted start
//   bus       regfile_loader_if.master: stream in, regfile write/read port
//   busy      high while writing or verifying
//   done      one-cycle completion pulse
//   err       sticky readback mismatch flag
//   err_addr  address of the first readback mismatch
module regfile_loader
   import regfile_loader_pkg::*;
#(
   parameter int N        = 64,
   parameter int LAST_REG = LAST_REG_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   regfile_loader_if.master  bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [4:0]        err_addr
);

   localparam logic [4:0] LAST_ADDR = 5'(LAST_REG);

   loader_state_t state_reg, state_next;
   logic [4:0]    addr_reg,  addr_next;
   logic          mode_reg,  mode_next;
   logic          write_fire;

`ifdef REGFILE_LOADER_VERIFY_EN
   logic          err_reg,      err_next;
   logic [4:0]    err_addr_reg, err_addr_next;
   logic          mismatch;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         addr_reg     <= 5'd0;
         mode_reg     <= 1'b0;
`ifdef REGFILE_LOADER_VERIFY_EN
         err_reg      <= 1'b0;
         err_addr_reg <= 5'd0;
`endif
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         mode_reg     <= mode_next;
`ifdef REGFILE_LOADER_VERIFY_EN
         err_reg      <= err_next;
         err_addr_reg <= err_addr_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      mode_next   = mode_reg;
      write_fire  = 1'b0;
      bus.s_ready = 1'b0;
      bus.we3     = 1'b0;
      bus.wa3     = 5'd0;
      bus.wd3     = '0;
      bus.ra1     = 5'd0;
      busy        = 1'b0;
      done        = 1'b0;
`ifdef REGFILE_LOADER_VERIFY_EN
      err_next      = err_reg;
      err_addr_next = err_addr_reg;
      mismatch      = 1'b0;
`endif

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = WRITE;
               addr_next  = 5'd0;
               mode_next  = mode;
`ifdef REGFILE_LOADER_VERIFY_EN
               err_next      = 1'b0;
               err_addr_next = 5'd0;
`endif
            end
         end

         WRITE: begin
            busy        = 1'b1;
            bus.s_ready = mode_reg;
            // Index mode writes every cycle; stream mode only on a handshake.
            write_fire  = !mode_reg || bus.s_valid;
            if (write_fire) begin
               bus.we3 = 1'b1;
               bus.wa3 = addr_reg;
               bus.wd3 = mode_reg ? bus.s_data : {{(N-5){1'b0}}, addr_reg};
               if (addr_reg == LAST_ADDR) begin
                  addr_next = 5'd0;
`ifdef REGFILE_LOADER_VERIFY_EN
                  // Streamed data is not kept, so only index fills are checked.
                  state_next = mode_reg ? DONE : VERIFY;
`else
                  state_next = DONE;
`endif
               end else begin
                  addr_next = addr_reg + 5'd1;
               end
            end
         end

`ifdef REGFILE_LOADER_VERIFY_EN
         VERIFY: begin
            busy     = 1'b1;
            bus.ra1  = addr_reg;
            mismatch = bus.rd1 != {{(N-5){1'b0}}, expected_index(addr_reg)};
            // Keep the first failing address; the walk always runs to X31.
            if (mismatch && !err_reg) begin
               err_next      = 1'b1;
               err_addr_next = addr_reg;
            end
            if (addr_reg == XZR_ADDR) begin
               addr_next  = 5'd0;
               state_next = DONE;
            end else begin
               addr_next = addr_reg + 5'd1;
            end
         end
`endif

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef REGFILE_LOADER_VERIFY_EN
   assign err      = err_reg;
   assign err_addr = err_addr_reg;
`else
   logic unused_rd1;
   assign unused_rd1 = ^bus.rd1;
   assign err        = 1'b0;
   assign err_addr   = 5'd0;
`endif

endmodule
